pool2x2_engine: RTL and testbench

//  Parametrised 2x2/stride-2 pooling layer for the CONV accelerator; successor to the fixed

---
 rtl/pool2x2_engine.sv | 184 ++++++++++++++++++
 tb/tb_pool2x2_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pool2x2_engine.sv
`default_nettype none
// ============================================================================
// Module      : pool2x2_engine
// Description : 2x2 / stride-2 pooling over CH feature maps (max or average),
//               reading and writing conv-layer memories via crd/cwr/csel bus.
// Revision    : 1.0 - initial release
// ============================================================================
module pool2x2_engine #(
  parameter int IMG_W       = 64,
  parameter int LOG_W       = 6,
  parameter int DW          = 20,
  parameter int CH          = 2,
  parameter int RD_SEL_BASE = 1,
  parameter int WR_SEL_BASE = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  output logic               busy,
  output logic               done,
  output logic               crd,
  output logic [2*LOG_W-1:0] caddr_rd,
  input  logic [DW-1:0]      cdata_rd,
  output logic               cwr,
  output logic [2*LOG_W-1:0] caddr_wr,
  output logic [DW-1:0]      cdata_wr,
  output logic [2:0]         csel
);

  // Window coordinates (row/col of the pooled map) need one bit less than LOG_W.
  localparam int CW = LOG_W - 1;
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_NXC  = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t              state_q;
  logic                busy_q, done_q, crd_q, cwr_q, mode_q;
  logic [2*LOG_W-1:0]  caddr_rd_q, caddr_wr_q;
  logic [DW-1:0]       cdata_wr_q;
  logic [2:0]          csel_q;
  logic [1:0]          k_q, ch_q;
  logic [CW-1:0]       col_q, row_q;
  logic [DW+1:0]       acc_q;

  logic [DW+1:0]       w_ext, w_sum, w_max, w_fold;
  logic [DW-1:0]       w_result;
  logic [1:0]          w_k_nxt;
  logic [CW-1:0]       w_col_nxt, w_row_nxt;
  logic                w_last_col, w_last_row, w_last_ch;
  logic [2:0]          w_rd_sel, w_wr_sel;

  // Accumulator is two bits wider than the data so a 4-sample sum never overflows;
  // in max mode it simply holds the running maximum.
  assign w_ext    = {2'b00, cdata_rd};
  assign w_sum    = acc_q + w_ext;
  assign w_max    = (w_ext > acc_q) ? w_ext : acc_q;
  assign w_fold   = mode_q ? w_sum : w_max;
  assign w_result = mode_q ? w_sum[DW+1:2] : w_max[DW-1:0];

  assign w_k_nxt    = k_q + 2'd1;
  assign w_last_col = (col_q == C_LAST);
  assign w_last_row = (row_q == C_LAST);
  assign w_last_ch  = (ch_q == 2'(CH - 1));
  // Column advances every window; row advances (and both wrap to 0) at the end of a line.
  assign w_col_nxt  = w_last_col ? '0 : col_q + CW'(1);
  assign w_row_nxt  = w_last_col ? row_q + CW'(1) : row_q;
  assign w_rd_sel   = 3'(RD_SEL_BASE) + {1'b0, ch_q};
  assign w_wr_sel   = 3'(WR_SEL_BASE) + {1'b0, ch_q};

  // Sequencer: walks windows and channels, folds samples and drives every bus output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      crd_q      <= 1'b0;
      cwr_q      <= 1'b0;
      mode_q     <= 1'b0;
      caddr_rd_q <= '0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
      csel_q     <= '0;
      k_q        <= '0;
      ch_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      acc_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q    <= S_RD;
            busy_q     <= 1'b1;
            mode_q     <= mode;
            k_q        <= '0;
            ch_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            acc_q      <= '0;
            crd_q      <= 1'b1;
            csel_q     <= 3'(RD_SEL_BASE);
            caddr_rd_q <= '0;
          end
        end
        S_RD: begin
          // The sample for read k-1 arrives while read k is being issued.
          if (k_q == 2'd1) begin
            acc_q <= w_ext;
          end else if (k_q != 2'd0) begin
            acc_q <= w_fold;
          end
          if (k_q == 2'd3) begin
            state_q <= S_CAP;
            crd_q   <= 1'b0;
          end else begin
            k_q        <= w_k_nxt;
            caddr_rd_q <= {row_q, w_k_nxt[1], col_q, w_k_nxt[0]};
          end
        end
        S_CAP: begin
          // Fourth sample is folded straight into the result.
          state_q    <= S_WR;
          cwr_q      <= 1'b1;
          csel_q     <= w_wr_sel;
          caddr_wr_q <= {2'b00, row_q, col_q};
          cdata_wr_q <= w_result;
        end
        S_WR: begin
          cwr_q <= 1'b0;
          k_q   <= '0;
          col_q <= w_col_nxt;
          row_q <= w_row_nxt;
          if (w_last_col && w_last_row) begin
            state_q <= S_NXC;
            csel_q  <= '0;
          end else begin
            state_q    <= S_RD;
            crd_q      <= 1'b1;
            csel_q     <= w_rd_sel;
            caddr_rd_q <= {w_row_nxt, 1'b0, w_col_nxt, 1'b0};
          end
        end
        S_NXC: begin
          if (w_last_ch) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q    <= S_RD;
            ch_q       <= ch_q + 2'd1;
            crd_q      <= 1'b1;
            csel_q     <= w_rd_sel + 3'd1;
            caddr_rd_q <= '0;
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign crd      = crd_q;
  assign caddr_rd = caddr_rd_q;
  assign cwr      = cwr_q;
  assign caddr_wr = caddr_wr_q;
  assign cdata_wr = cdata_wr_q;
  assign csel     = csel_q;

endmodule
`default_nettype wire

// File: tb/tb_pool2x2_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool2x2_engine
// Description : Scoreboard bench for pool2x2_engine: three instances (4x4/CH1,
//               4x4/CH2, 64x64/CH2) sharing one memory image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool2x2_engine;

  typedef struct {
    logic [2:0]  sel;
    logic [11:0] addr;
    logic [19:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic st[3];
  logic md[3];

  logic bsy0, dn0, rd0, wr0; logic [3:0]  ar0, aw0; logic [19:0] di0 = '0, do0; logic [2:0] cs0;
  logic bsy1, dn1, rd1, wr1; logic [3:0]  ar1, aw1; logic [19:0] di1 = '0, do1; logic [2:0] cs1;
  logic bsy2, dn2, rd2, wr2; logic [11:0] ar2, aw2; logic [19:0] di2 = '0, do2; logic [2:0] cs2;

  logic [19:0] mem [0:7][0:4095];
  exp_t        q [3][$];
  int          done_cnt [3];
  int          done_cyc [3];
  int          start_cyc [3];
  int          busy_cnt [3];
  int          wr_cnt [3];
  logic [19:0] wlog [16];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  pool2x2_engine #(.IMG_W(4), .LOG_W(2), .DW(20), .CH(1), .RD_SEL_BASE(1), .WR_SEL_BASE(3)) u_d0 (
    .clk(clk), .reset(reset), .start(st[0]), .mode(md[0]), .busy(bsy0), .done(dn0),
    .crd(rd0), .caddr_rd(ar0), .cdata_rd(di0), .cwr(wr0), .caddr_wr(aw0), .cdata_wr(do0), .csel(cs0));
  pool2x2_engine #(.IMG_W(4), .LOG_W(2), .DW(20), .CH(2), .RD_SEL_BASE(1), .WR_SEL_BASE(3)) u_d1 (
    .clk(clk), .reset(reset), .start(st[1]), .mode(md[1]), .busy(bsy1), .done(dn1),
    .crd(rd1), .caddr_rd(ar1), .cdata_rd(di1), .cwr(wr1), .caddr_wr(aw1), .cdata_wr(do1), .csel(cs1));
  pool2x2_engine u_d2 (
    .clk(clk), .reset(reset), .start(st[2]), .mode(md[2]), .busy(bsy2), .done(dn2),
    .crd(rd2), .caddr_rd(ar2), .cdata_rd(di2), .cwr(wr2), .caddr_wr(aw2), .cdata_wr(do2), .csel(cs2));

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rd0) di0 <= mem[cs0][ar0];
    if (rd1) di1 <= mem[cs1][ar1];
    if (rd2) di2 <= mem[cs2][ar2];
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: pooled map of every channel from the memory image.
  task automatic model(input int d, input int w, input int nch, input bit avg);
    int hw = w / 2;
    for (int ch = 0; ch < nch; ch++)
      for (int r = 0; r < hw; r++)
        for (int c = 0; c < hw; c++) begin
          int unsigned s [4];
          int unsigned sum = 0, mx = 0;
          exp_t e;
          s[0] = mem[1+ch][(2*r)*w + 2*c];
          s[1] = mem[1+ch][(2*r)*w + 2*c + 1];
          s[2] = mem[1+ch][(2*r+1)*w + 2*c];
          s[3] = mem[1+ch][(2*r+1)*w + 2*c + 1];
          foreach (s[i]) begin
            sum += s[i];
            if (s[i] > mx) mx = s[i];
          end
          e.sel  = 3'(3 + ch);
          e.addr = 12'(r*hw + c);
          e.data = avg ? 20'(sum / 4) : 20'(mx);
          q[d].push_back(e);
        end
  endtask

  task automatic mon(input int d, input logic bsy, input logic dn, input logic rd, input logic wr,
                     input logic [11:0] aw, input logic [19:0] dw, input logic [2:0] sel);
    exp_t e;
    if (rd || wr) chk($sformatf("d%0d rd_wr_exclusive", d), longint'(rd && wr), 0);
    if (wr) begin
      wr_cnt[d]++;
      if (d == 0) wlog[aw[3:0]] = dw;
      if (q[d].size() == 0) begin
        chk($sformatf("d%0d unexpected_write addr", d), longint'(aw), -1);
      end else begin
        e = q[d].pop_front();
        chk($sformatf("d%0d wr_sel", d), longint'(sel), longint'(e.sel));
        chk($sformatf("d%0d wr_addr", d), longint'(aw), longint'(e.addr));
        chk($sformatf("d%0d wr_data@%0h", d, e.addr), longint'(dw), longint'(e.data));
      end
    end
    if (dn) begin
      done_cnt[d]++;
      done_cyc[d] = cyc;
      chk($sformatf("d%0d busy_at_done", d), longint'(bsy), 0);
    end
    if (bsy) busy_cnt[d]++;
  endtask

  always @(negedge clk) begin
    mon(0, bsy0, dn0, rd0, wr0, 12'(aw0), do0, cs0);
    mon(1, bsy1, dn1, rd1, wr1, 12'(aw1), do1, cs1);
    mon(2, bsy2, dn2, rd2, wr2, aw2, do2, cs2);
  end

  task automatic pulse_start(input int d, input bit m);
    @(negedge clk);
    st[d] = 1'b1;
    md[d] = m;
    start_cyc[d] = cyc;
    @(negedge clk);
    st[d] = 1'b0;
    md[d] = ~m;
  endtask

  task automatic wait_done(input int d, input int n0, input int budget);
    int t = 0;
    while (done_cnt[d] == n0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk($sformatf("d%0d done_seen", d), longint'(done_cnt[d] != n0), 1);
    repeat (3) @(posedge clk);
    chk($sformatf("d%0d pending_writes", d), longint'(q[d].size()), 0);
  endtask

  task automatic fill(input int sel, input int n, input bit ramp);
    for (int i = 0; i < n; i++) mem[sel][i] = ramp ? 20'(i) : 20'($urandom);
  endtask

  initial begin
    int n0;
    reset = 1'b1;
    foreach (st[i]) begin st[i] = 1'b0; md[i] = 1'b0; end
    for (int s = 0; s < 8; s++) fill(s, 4096, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("d0 reset_outputs", longint'({bsy0, dn0, rd0, wr0, cs0, ar0, aw0, do0}), 0);
    chk("d1 reset_outputs", longint'({bsy1, dn1, rd1, wr1, cs1, ar1, aw1, do1}), 0);
    chk("d2 reset_outputs", longint'({bsy2, dn2, rd2, wr2, cs2, ar2, aw2, do2}), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 4x4 single channel, max over a ramp.
    fill(1, 16, 1'b1);
    model(0, 4, 1, 1'b0);
    n0 = done_cnt[0];
    pulse_start(0, 1'b0);
    wait_done(0, n0, 100);
    chk("d0 done_latency", longint'(done_cyc[0] - start_cyc[0]), 26);
    chk("d0 ramp_w0", longint'(wlog[0]), 5);
    chk("d0 ramp_w1", longint'(wlog[1]), 7);
    chk("d0 ramp_w2", longint'(wlog[2]), 13);
    chk("d0 ramp_w3", longint'(wlog[3]), 15);

    // Average: floor of a small window, and all-ones window must not saturate/overflow.
    fill(1, 16, 1'b0);
    mem[1][0] = 20'd1; mem[1][1] = 20'd2; mem[1][4] = 20'd3; mem[1][5] = 20'd4;
    mem[1][2] = 20'hFFFFF; mem[1][3] = 20'hFFFFF; mem[1][6] = 20'hFFFFF; mem[1][7] = 20'hFFFFF;
    model(0, 4, 1, 1'b1);
    n0 = done_cnt[0];
    pulse_start(0, 1'b1);
    wait_done(0, n0, 100);
    chk("d0 avg_floor", longint'(wlog[0]), 2);
    chk("d0 avg_full", longint'(wlog[1]), 20'hFFFFF);

    // Equal samples, then start with flipped mode while busy must be ignored.
    for (int i = 0; i < 16; i++) mem[1][i] = (i < 8) ? 20'h1234 : 20'($urandom);
    model(0, 4, 1, 1'b0);
    n0 = done_cnt[0];
    pulse_start(0, 1'b0);
    repeat (3) @(negedge clk);
    pulse_start(0, 1'b1);
    wait_done(0, n0, 100);
    repeat (10) @(posedge clk);
    chk("d0 single_done", longint'(done_cnt[0] - n0), 1);

    // Two channels with distinct contents.
    fill(1, 16, 1'b0);
    for (int i = 0; i < 16; i++) mem[2][i] = 20'(mem[1][i] ^ 20'h5A5A5);
    model(1, 4, 2, 1'b0);
    n0 = done_cnt[1];
    pulse_start(1, 1'b0);
    wait_done(1, n0, 200);
    chk("d1 write_count", longint'(wr_cnt[1]), 8);

    // Full-size average run.
    fill(1, 4096, 1'b0);
    fill(2, 4096, 1'b0);
    model(2, 64, 2, 1'b1);
    n0 = done_cnt[2];
    busy_cnt[2] = 0;
    pulse_start(2, 1'b1);
    wait_done(2, n0, 20000);
    chk("d2 write_count", longint'(wr_cnt[2]), 2048);
    chk("d2 busy_width", longint'(busy_cnt[2]), 2 * (1024 * 6 + 1));

    // Reset during read k=2 of the second window, then a clean rerun.
    fill(1, 16, 1'b0);
    model(0, 4, 1, 1'b0);
    n0 = done_cnt[0];
    pulse_start(0, 1'b0);
    repeat (8) @(posedge clk);
    #2;
    reset = 1'b1;
    q[0].delete();
    @(negedge clk);
    chk("d0 abort_outputs", longint'({bsy0, dn0, rd0, wr0, cs0, ar0, aw0, do0}), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("d0 abort_no_done", longint'(done_cnt[0] - n0), 0);
    model(0, 4, 1, 1'b0);
    n0 = done_cnt[0];
    pulse_start(0, 1'b0);
    wait_done(0, n0, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
